// File: rtl/fft_stage_ctrl_pkg.sv
// Shared constants and phase encoding for one radix-2 SDF FFT stage controller.
package fft_stage_ctrl_pkg;

  localparam int TF_NUM           = 128;
  localparam int BRAM_TF_ADDR_LEN = 7;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } phase_e;

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Sample-handshake, FIFO-control and status bundle between a stage and its controller.
interface fft_stage_ctrl_if
  import fft_stage_ctrl_pkg::*;
#(
  parameter int addr_len = BRAM_TF_ADDR_LEN
);
  logic                clr;
  logic                data_in_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_wr_en;
  logic                fifo_rd_en;
  logic                pair_valid;
  logic [addr_len-1:0] tf_addr;
  logic                phase;
  logic                frame_done;
  logic                err_ovf;
  logic                err_unf;

  modport master (
    output clr, data_in_valid, fifo_full, fifo_empty,
    input  fifo_wr_en, fifo_rd_en, pair_valid, tf_addr, phase, frame_done, err_ovf, err_unf
  );

  modport slave (
    input  clr, data_in_valid, fifo_full, fifo_empty,
    output fifo_wr_en, fifo_rd_en, pair_valid, tf_addr, phase, frame_done, err_ovf, err_unf
  );
endinterface

// File: rtl/fft_tf_addr_gen.sv
// Twiddle address = (cnt * stride) mod 2^addr_len; stride is a power of two so this is a shift.
module fft_tf_addr_gen #(
  parameter int addr_len = 7,
  parameter int stride   = 1
) (
  input  logic [addr_len-1:0] cnt,
  output logic [addr_len-1:0] addr
);
  localparam int STRIDE_SHIFT = $clog2(stride);

  // Truncation to addr_len bits performs the modulo for free.
  assign addr = cnt << STRIDE_SHIFT;
endmodule

// File: rtl/fft_stage_ctrl.sv
// Counter-based FILL/PAIR sequencer for a radix-2 single-delay-feedback FFT stage.
module fft_stage_ctrl
  import fft_stage_ctrl_pkg::*;
#(
  parameter int tf_num           = TF_NUM,
  parameter int bram_tf_addr_len = BRAM_TF_ADDR_LEN,
  parameter int tf_stride        = 1
) (
  input logic             clk,
  input logic             rst,
  fft_stage_ctrl_if.slave bus
);
  localparam logic [bram_tf_addr_len-1:0] CNT_MAX = bram_tf_addr_len'(tf_num - 1);

  phase_e                      phase_reg, phase_next;
  logic [bram_tf_addr_len-1:0] cnt_reg, cnt_next;
  logic [bram_tf_addr_len-1:0] tf_addr_reg, tf_addr_next;
  logic                        pair_valid_reg, pair_valid_next;
  logic                        frame_done_reg, frame_done_next;
  logic                        err_ovf_reg, err_ovf_next;
  logic                        err_unf_reg, err_unf_next;
  logic [bram_tf_addr_len-1:0] tf_addr_calc;
  logic                        sample_ok;
  logic                        wr_en;
  logic                        rd_en;
  logic                        last_sample;

  // A sample coincident with clr is dropped; rst also gates the strobes.
  assign sample_ok   = bus.data_in_valid & ~bus.clr & ~rst;
  assign wr_en       = sample_ok & (phase_reg == FILL);
  assign rd_en       = sample_ok & (phase_reg == PAIR);
  assign last_sample = (cnt_reg == CNT_MAX);

  fft_tf_addr_gen #(
    .addr_len (bram_tf_addr_len),
    .stride   (tf_stride)
  ) u_tf_addr_gen (
    .cnt  (cnt_reg),
    .addr (tf_addr_calc)
  );

  always_comb begin
    phase_next      = phase_reg;
    cnt_next        = cnt_reg;
    tf_addr_next    = tf_addr_reg;
    pair_valid_next = rd_en;
    frame_done_next = rd_en & last_sample;
    err_ovf_next    = err_ovf_reg | (wr_en & bus.fifo_full);
    err_unf_next    = err_unf_reg | (rd_en & bus.fifo_empty);

    if (rd_en) begin
      tf_addr_next = tf_addr_calc;
    end

    if (bus.clr) begin
      phase_next      = FILL;
      cnt_next        = '0;
      pair_valid_next = 1'b0;
      frame_done_next = 1'b0;
      err_ovf_next    = 1'b0;
      err_unf_next    = 1'b0;
    end else if (bus.data_in_valid) begin
      cnt_next = cnt_reg + 1'b1;
      if (last_sample) begin
        phase_next = (phase_reg == FILL) ? PAIR : FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg      <= FILL;
      cnt_reg        <= '0;
      tf_addr_reg    <= '0;
      pair_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      err_ovf_reg    <= 1'b0;
      err_unf_reg    <= 1'b0;
    end else begin
      phase_reg      <= phase_next;
      cnt_reg        <= cnt_next;
      tf_addr_reg    <= tf_addr_next;
      pair_valid_reg <= pair_valid_next;
      frame_done_reg <= frame_done_next;
      err_ovf_reg    <= err_ovf_next;
      err_unf_reg    <= err_unf_next;
    end
  end

  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_rd_en = rd_en;
  assign bus.pair_valid = pair_valid_reg;
  assign bus.tf_addr    = tf_addr_reg;
  assign bus.phase      = phase_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.err_ovf    = err_ovf_reg;
  assign bus.err_unf    = err_unf_reg;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: stride-1 and stride-4 instances driven in lockstep, pair scoreboard.
module tb_fft_stage_ctrl;
  import fft_stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_stage_ctrl_if if1 ();
  fft_stage_ctrl_if if4 ();

  assign if4.clr           = if1.clr;
  assign if4.data_in_valid = if1.data_in_valid;
  assign if4.fifo_full     = if1.fifo_full;
  assign if4.fifo_empty    = if1.fifo_empty;

  fft_stage_ctrl #(.tf_stride(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  fft_stage_ctrl #(.tf_stride(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    int idx;
    bit last;
    int cyc;
  } pair_t;

  pair_t pq[$];
  int    tbfifo[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pairs_seen = 0;
  int fd_seen = 0;
  int zero4_seen = 0;
  int last_addr4 = -1;

  bit m_phase, m_ovf, m_unf;
  int m_cnt;
  int sample_idx;
  bit force_full, force_empty;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pair_valid must match the oldest expected read, one cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      if (if1.pair_valid) begin
        pair_t e;
        pairs_seen++;
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected cyc=%0d got pair_valid=1 required 0", cyc);
        end else begin
          e = pq.pop_front();
          $display("pair cyc=%0d idx=%0d tf1=%0d tf4=%0d fd=%b", cyc, e.idx, if1.tf_addr, if4.tf_addr, if1.frame_done);
          if (e.cyc !== cyc) begin
            errors++;
            $display("FAIL pair_timing got cyc=%0d required cyc=%0d", cyc, e.cyc);
          end
          checks++;
          if (if1.tf_addr !== 7'(e.idx)) begin
            errors++;
            $display("FAIL tf_addr_s1 got %0d required %0d", if1.tf_addr, e.idx);
          end
          checks++;
          if (if4.tf_addr !== 7'((e.idx * 4) % 128)) begin
            errors++;
            $display("FAIL tf_addr_s4 got %0d required %0d", if4.tf_addr, (e.idx * 4) % 128);
          end
          checks++;
          if (if1.frame_done !== e.last) begin
            errors++;
            $display("FAIL frame_done got %b required %b", if1.frame_done, e.last);
          end
          checks++;
          if (if4.pair_valid !== 1'b1) begin
            errors++;
            $display("FAIL pair_valid_s4 got %b required 1", if4.pair_valid);
          end
          if (if1.frame_done) fd_seen++;
          if (if4.tf_addr == 7'd0) zero4_seen++;
          last_addr4 = int'(if4.tf_addr);
        end
      end else begin
        checks++;
        if (if1.frame_done !== 1'b0 || if4.pair_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_strobes cyc=%0d got fd=%b pv4=%b required 0 0", cyc, if1.frame_done, if4.pair_valid);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_phase = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    tbfifo.delete();
    pq.delete();
  endtask

  task automatic step(input bit v, input bit c);
    bit exp_wr, exp_rd, full_now, empty_now;
    int x1;
    @(posedge clk); #1;
    full_now  = force_full || (tbfifo.size() >= 128);
    empty_now = force_empty || (tbfifo.size() == 0);
    if1.data_in_valid = v;
    if1.clr           = c;
    if1.fifo_full     = full_now;
    if1.fifo_empty    = empty_now;
    exp_wr = v && !c && !m_phase;
    exp_rd = v && !c && m_phase;
    @(negedge clk);
    checks++;
    if (if1.fifo_wr_en !== exp_wr) begin
      errors++;
      $display("FAIL wr_en cyc=%0d got %b required %b", cyc, if1.fifo_wr_en, exp_wr);
    end
    checks++;
    if (if1.fifo_rd_en !== exp_rd) begin
      errors++;
      $display("FAIL rd_en cyc=%0d got %b required %b", cyc, if1.fifo_rd_en, exp_rd);
    end
    checks++;
    if (if1.phase !== m_phase) begin
      errors++;
      $display("FAIL phase cyc=%0d got %b required %b", cyc, if1.phase, m_phase);
    end
    checks++;
    if (if1.err_ovf !== m_ovf || if1.err_unf !== m_unf) begin
      errors++;
      $display("FAIL err_flags cyc=%0d got ovf=%b unf=%b required %b %b", cyc, if1.err_ovf, if1.err_unf, m_ovf, m_unf);
    end
    if (if1.fifo_wr_en) tbfifo.push_back(sample_idx);
    if (if1.fifo_rd_en) begin
      checks++;
      if (tbfifo.size() == 0) begin
        errors++;
        $display("FAIL x1x2_read_empty cyc=%0d got empty fifo required entry", cyc);
      end else begin
        x1 = tbfifo.pop_front();
        if (sample_idx - x1 != 128) begin
          errors++;
          $display("FAIL x1x2_distance got %0d required 128", sample_idx - x1);
        end
      end
    end
    if (exp_rd) pq.push_back('{m_cnt, (m_cnt == 127), cyc + 1});
    if (c) begin
      m_phase = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      tbfifo.delete();
    end else if (v) begin
      if (exp_wr && full_now)  m_ovf = 1'b1;
      if (exp_rd && empty_now) m_unf = 1'b1;
      if (m_cnt == 127) m_phase = !m_phase;
      m_cnt = (m_cnt + 1) % 128;
      sample_idx++;
    end
  endtask

  task automatic drain_and_check(input string name, input int pairs0, input int pairs_exp,
                                 input int fd0, input int fd_exp);
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (pairs_seen - pairs0 != pairs_exp || pq.size() != 0) begin
      errors++;
      $display("FAIL %s_pairs got %0d (pending %0d) required %0d", name, pairs_seen - pairs0, pq.size(), pairs_exp);
    end
    checks++;
    if (fd_seen - fd0 != fd_exp) begin
      errors++;
      $display("FAIL %s_frame_done got %0d required %0d", name, fd_seen - fd0, fd_exp);
    end
  endtask

  task automatic test_reset();
    int p0, f0;
    checks++;
    if ({if1.phase, if1.pair_valid, if1.frame_done, if1.err_ovf, if1.err_unf,
         if1.fifo_wr_en, if1.fifo_rd_en, if1.tf_addr} !== 14'd0) begin
      errors++;
      $display("FAIL reset_powerup got %b required 0", {if1.phase, if1.pair_valid, if1.frame_done,
               if1.err_ovf, if1.err_unf, if1.fifo_wr_en, if1.fifo_rd_en, if1.tf_addr});
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (165) step(1'b1, 1'b0);
    @(posedge clk); #1;
    if1.data_in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if1.phase, if1.pair_valid, if1.frame_done, if1.err_ovf, if1.err_unf,
         if1.fifo_wr_en, if1.fifo_rd_en, if1.tf_addr} !== 14'd0) begin
      errors++;
      $display("FAIL reset_midframe got %b required 0", {if1.phase, if1.pair_valid, if1.frame_done,
               if1.err_ovf, if1.err_unf, if1.fifo_wr_en, if1.fifo_rd_en, if1.tf_addr});
    end
    checks++;
    if ({if4.pair_valid, if4.tf_addr, if4.phase} !== 9'd0) begin
      errors++;
      $display("FAIL reset_midframe_s4 got %b required 0", {if4.pair_valid, if4.tf_addr, if4.phase});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    if1.data_in_valid = 1'b0;
    model_reset();
    p0 = pairs_seen; f0 = fd_seen;
    repeat (256) step(1'b1, 1'b0);
    drain_and_check("reset_frame", p0, 128, f0, 1);
  endtask

  task automatic test_continuous();
    int p0 = pairs_seen, f0 = fd_seen;
    repeat (256) step(1'b1, 1'b0);
    drain_and_check("continuous", p0, 128, f0, 1);
  endtask

  task automatic test_stalls();
    int p0 = pairs_seen, f0 = fd_seen;
    for (int i = 0; i < 1024; i++) step((i % 4 == 0) || (i % 4 == 3), 1'b0);
    drain_and_check("stalls", p0, 256, f0, 2);
  endtask

  task automatic test_stride();
    int p0 = pairs_seen, f0 = fd_seen, z0 = zero4_seen;
    repeat (256) step(1'b1, 1'b0);
    drain_and_check("stride", p0, 128, f0, 1);
    checks++;
    if (zero4_seen - z0 != 4 || last_addr4 != 124) begin
      errors++;
      $display("FAIL stride_wrap got zeros=%0d last=%0d required 4 124", zero4_seen - z0, last_addr4);
    end
  endtask

  task automatic test_errors();
    step(1'b0, 1'b1);
    for (int i = 0; i < 128; i++) begin
      force_full = (i >= 10 && i < 13);
      step(1'b1, 1'b0);
    end
    force_full = 1'b0;
    for (int i = 0; i < 128; i++) begin
      force_empty = (i < 5);
      step(1'b1, 1'b0);
    end
    force_empty = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    checks++;
    if (if1.err_ovf !== 1'b1 || if1.err_unf !== 1'b1) begin
      errors++;
      $display("FAIL errors_sticky got ovf=%b unf=%b required 1 1", if1.err_ovf, if1.err_unf);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (if1.err_ovf !== 1'b0 || if1.err_unf !== 1'b0) begin
      errors++;
      $display("FAIL errors_clr got ovf=%b unf=%b required 0 0", if1.err_ovf, if1.err_unf);
    end
  endtask

  task automatic test_clr();
    int p0, f0;
    repeat (90) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (if1.phase !== 1'b0 || if1.pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_state got phase=%b pv=%b required 0 0", if1.phase, if1.pair_valid);
    end
    p0 = pairs_seen; f0 = fd_seen;
    repeat (256) step(1'b1, 1'b0);
    drain_and_check("clr_frame", p0, 128, f0, 1);
  endtask

  initial begin
    if1.clr = 1'b0;
    if1.data_in_valid = 1'b0;
    if1.fifo_full = 1'b0;
    if1.fifo_empty = 1'b1;
    force_full = 1'b0;
    force_empty = 1'b0;
    sample_idx = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_stalls();
    test_stride();
    test_errors();
    test_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
